// File: rtl/typepkg.sv
// rtl/typepkg.sv - shared types for the instruction fetch unit
package typepkg;
  typedef enum logic [1:0] {IDLE, FETCH, HOLD} fetch_state_t;
endpackage

// File: rtl/pc_counter.sv
// rtl/pc_counter.sv - program counter with load, increment and natural wrap
module pc_counter #(
  parameter int          ADDR_N   = 16,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_N-1:0] pc_in,
  output logic [ADDR_N-1:0] pc
);
  always_ff @(posedge clk) begin
    if (!n_reset)
      pc <= ADDR_N'(RESET_PC);
    else if (load)
      pc <= pc_in;
    else if (inc)
      pc <= pc + 1'b1;
  end
endmodule

// File: rtl/cpu_fetch.sv
// rtl/cpu_fetch.sv - multi-byte instruction fetch with wait states and handshake
module cpu_fetch
  import typepkg::*;
#(
  parameter int          ADDR_N    = 16,
  parameter int          DATA_N    = 8,
  parameter int          MAX_BYTES = 3,
  parameter int unsigned RESET_PC  = 0
) (
  input  logic                           clk,
  input  logic                           n_reset,
  output logic                           bus_oe,
  output logic [ADDR_N-1:0]              bus_addr,
  input  logic [DATA_N-1:0]              bus_rdata,
  input  logic                           bus_ready,
  input  logic                           start,
  input  logic [$clog2(MAX_BYTES+1)-1:0] len,
  output logic                           valid,
  input  logic                           accept,
  output logic [MAX_BYTES*DATA_N-1:0]    ins_bytes,
  input  logic                           pc_load,
  input  logic [ADDR_N-1:0]              pc_in,
  output logic [ADDR_N-1:0]              pc
);
  localparam int LEN_W = $clog2(MAX_BYTES+1);

  fetch_state_t      state_q, state_d;
  logic [LEN_W-1:0]  len_q, count_q, len_eff;
  logic [DATA_N-1:0] byte_q [MAX_BYTES];
  logic              take_start, load_len, capture;

  assign len_eff    = (len > LEN_W'(MAX_BYTES)) ? LEN_W'(MAX_BYTES) : len;
  assign take_start = start && (len != '0);
  assign capture    = (state_q == FETCH) && bus_ready && !pc_load;
  assign bus_oe     = (state_q == FETCH);
  assign bus_addr   = pc;
  assign valid      = (state_q == HOLD);

  pc_counter #(.ADDR_N(ADDR_N), .RESET_PC(RESET_PC)) u_pc (
    .clk     (clk),
    .n_reset (n_reset),
    .load    (pc_load),
    .inc     (capture),
    .pc_in   (pc_in),
    .pc      (pc)
  );

  always_comb begin
    state_d  = state_q;
    load_len = 1'b0;
    case (state_q)
      IDLE: if (take_start) begin
        state_d  = FETCH;
        load_len = 1'b1;
      end
      FETCH: if (bus_ready && (count_q == len_q - 1'b1)) state_d = HOLD;
      HOLD: if (accept) begin
        if (take_start) begin
          state_d  = FETCH;
          load_len = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A jump abandons whatever is in flight, including a pending back-to-back start
    if (pc_load) begin
      state_d  = IDLE;
      load_len = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q <= IDLE;
      len_q   <= '0;
      count_q <= '0;
      for (int i = 0; i < MAX_BYTES; i++) byte_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (pc_load) begin
        count_q <= '0;
        for (int i = 0; i < MAX_BYTES; i++) byte_q[i] <= '0;
      end else if (load_len) begin
        len_q   <= len_eff;
        count_q <= '0;
        for (int i = 0; i < MAX_BYTES; i++) byte_q[i] <= '0;
      end else if (capture) begin
        for (int i = 0; i < MAX_BYTES; i++)
          if (count_q == LEN_W'(i)) byte_q[i] <= bus_rdata;
        count_q <= count_q + 1'b1;
      end
    end
  end

  always_comb begin
    ins_bytes = '0;
    for (int i = 0; i < MAX_BYTES; i++) ins_bytes[i*DATA_N +: DATA_N] = byte_q[i];
  end
endmodule

// File: tb/tb_cpu_fetch.sv
// tb/tb_cpu_fetch.sv - scoreboard bench for cpu_fetch
module tb_cpu_fetch;
  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic        bus_oe;
  logic [15:0] bus_addr;
  logic [7:0]  bus_rdata;
  logic        bus_ready = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  len = '0;
  logic        valid;
  logic        accept = 1'b0;
  logic [23:0] ins_bytes;
  logic        pc_load = 1'b0;
  logic [15:0] pc_in = '0;
  logic [15:0] pc;

  logic [7:0]  mem [0:65535];
  logic [23:0] exp_q [$];
  logic [23:0] last_exp;
  logic [15:0] pc_m;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;
  assign bus_rdata = mem[bus_addr];

  cpu_fetch #(.ADDR_N(16), .DATA_N(8), .MAX_BYTES(3), .RESET_PC(0)) dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .bus_oe    (bus_oe),
    .bus_addr  (bus_addr),
    .bus_rdata (bus_rdata),
    .bus_ready (bus_ready),
    .start     (start),
    .len       (len),
    .valid     (valid),
    .accept    (accept),
    .ins_bytes (ins_bytes),
    .pc_load   (pc_load),
    .pc_in     (pc_in),
    .pc        (pc)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int n);
    logic [23:0] e;
    logic [15:0] a;
    e = '0;
    for (int i = 0; i < n; i++) begin
      a = pc_m + 16'(i);
      e[i*8 +: 8] = mem[a];
    end
    exp_q.push_back(e);
    pc_m = pc_m + 16'(n);
  endtask

  task automatic pop_check(input string tag);
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 1, 0);
    end else begin
      last_exp = exp_q.pop_front();
      check(tag, ins_bytes, last_exp);
    end
  endtask

  task automatic fetch(input int n, input int waits);
    int          cyc;
    logic [15:0] a;
    @(negedge clk);
    start = 1'b1; len = 2'(n); bus_ready = 1'b1;
    a = pc_m;
    push_exp(n);
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    for (int b = 0; b < n; b++) begin
      for (int w = 0; w < waits; w++) begin
        bus_ready = 1'b0;
        check("wait_oe", bus_oe, 1);
        check("wait_addr", bus_addr, a);
        @(negedge clk);
        cyc++;
      end
      bus_ready = 1'b1;
      check("fetch_valid_low", valid, 0);
      check("fetch_addr", bus_addr, a);
      @(negedge clk);
      cyc++;
      a = a + 1'b1;
    end
    check("valid", valid, 1);
    check("hold_oe", bus_oe, 0);
    check("latency", cyc, n * (waits + 1) + 1);
    check("pc", pc, pc_m);
    pop_check("ins_bytes");
  endtask

  task automatic consume();
    accept = 1'b1;
    @(negedge clk);
    accept = 1'b0;
    check("accept_valid", valid, 0);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i * 7 + 3);
    mem[0] = 8'h10; mem[1] = 8'h20; mem[2] = 8'h30;
    pc_m = '0;

    repeat (3) @(negedge clk);
    check("rst_pc", pc, 0);
    check("rst_valid", valid, 0);
    check("rst_oe", bus_oe, 0);
    check("rst_ins", ins_bytes, 0);
    n_reset = 1'b1;

    fetch(3, 0);
    check("first_ins", ins_bytes, 24'h302010);
    consume();

    fetch(2, 2);
    consume();

    @(negedge clk);
    pc_load = 1'b1; pc_in = 16'hFFFF;
    @(negedge clk);
    pc_load = 1'b0;
    pc_m = 16'hFFFF;
    check("load_pc", pc, 16'hFFFF);
    fetch(2, 0);
    check("wrap_ins", ins_bytes, {8'h00, 8'h10, mem[16'hFFFF]});
    check("wrap_pc", pc, 16'h0001);
    consume();

    // Abort a fetch after one byte
    @(negedge clk);
    start = 1'b1; len = 2'd3;
    @(negedge clk);
    start = 1'b0; bus_ready = 1'b1;
    @(negedge clk);
    pc_load = 1'b1; pc_in = 16'h0100;
    @(negedge clk);
    pc_load = 1'b0;
    pc_m = 16'h0100;
    check("abort_pc", pc, 16'h0100);
    check("abort_valid", valid, 0);
    check("abort_oe", bus_oe, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_idle_oe", bus_oe, 0);
    end

    // Start ignored in HOLD without accept, then back-to-back
    fetch(2, 0);
    start = 1'b1; len = 2'd1;
    @(negedge clk);
    check("hold_keep_valid", valid, 1);
    check("hold_keep_ins", ins_bytes, last_exp);
    check("hold_no_oe", bus_oe, 0);
    check("hold_pc", pc, 16'h0102);
    accept = 1'b1; start = 1'b1; len = 2'd1;
    push_exp(1);
    @(negedge clk);
    accept = 1'b0; start = 1'b0;
    check("b2b_valid_low", valid, 0);
    check("b2b_oe", bus_oe, 1);
    check("b2b_addr", bus_addr, 16'h0102);
    @(negedge clk);
    check("b2b_valid", valid, 1);
    pop_check("b2b_ins");
    check("b2b_upper_zero", ins_bytes[23:8], 0);
    check("b2b_pc", pc, 16'h0103);
    consume();

    @(negedge clk);
    start = 1'b1; len = 2'd0;
    @(negedge clk);
    start = 1'b0;
    check("len0_oe", bus_oe, 0);
    @(negedge clk);
    check("len0_oe2", bus_oe, 0);
    check("len0_valid", valid, 0);

    // Reset in the middle of a fetch
    @(negedge clk);
    start = 1'b1; len = 2'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    n_reset = 1'b0;
    @(negedge clk);
    n_reset = 1'b1;
    pc_m = '0;
    check("mid_rst_pc", pc, 0);
    check("mid_rst_oe", bus_oe, 0);
    check("mid_rst_valid", valid, 0);
    check("mid_rst_ins", ins_bytes, 0);

    fetch(3, 1);
    check("post_rst_ins", ins_bytes, 24'h302010);
    consume();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cpu_fetch.md
CPU_FETCH -- requirements
Module: cpu_fetch

Interface
REQ-001 SHALL have parameter ADDR_N, default 16, address width in bits.
REQ-002 SHALL have parameter DATA_N, default 8, data width in bits.
REQ-003 SHALL have parameter MAX_BYTES, default 3, maximum instruction length in bytes (1..8).
REQ-004 SHALL have parameter RESET_PC, default 0, program counter value after reset.
REQ-005 clk  input  1  system clock; all state changes on rising edge.
REQ-006 n_reset  input  1  reset, synchronous and active-low.
REQ-007 bus_oe  output  1  memory read request; address valid while high.
REQ-008 bus_addr  output  ADDR_N  read address, equal to current PC.
REQ-009 bus_rdata  input  DATA_N  read data, sampled when bus_oe && bus_ready.
REQ-010 bus_ready  input  1  memory completes read this cycle; low inserts wait states.
REQ-011 start  input  1  request fetch of len bytes from PC.
REQ-012 len  input  $clog2(MAX_BYTES+1)  number of bytes to fetch.
REQ-013 valid  output  1  ins_bytes holds a complete instruction.
REQ-014 accept  input  1  consumer takes ins_bytes; completes handshake when valid.
REQ-015 ins_bytes  output  MAX_BYTES*DATA_N  fetched bytes, byte 0 (opcode) in bits [DATA_N-1:0].
REQ-016 pc_load  input  1  load PC from pc_in (jump/branch/vector).
REQ-017 pc_in  input  ADDR_N  new PC value.
REQ-018 pc  output  ADDR_N  current program counter.

Function
REQ-019 SHALL implement FSM states IDLE, FETCH, HOLD.
REQ-020 IDLE: start with len>=1 SHALL latch len (clamped to MAX_BYTES), clear byte count, clear ins_bytes, enter FETCH next cycle; start with len==0 SHALL be ignored.
REQ-021 FETCH: bus_oe SHALL be 1 and bus_addr SHALL equal pc; bus_oe SHALL be 0 in IDLE and HOLD.
REQ-022 FETCH with bus_ready=1: byte[count] SHALL capture bus_rdata, pc SHALL increment by 1, count SHALL increment; bus_ready=0 SHALL hold all state.
REQ-023 Capture of the last byte (count==len-1) SHALL enter HOLD with valid=1 on the following cycle; latency from start to valid = len + wait cycles + 1.
REQ-024 HOLD: valid SHALL stay 1 and ins_bytes stable until accept=1; accept alone SHALL return to IDLE with valid=0 next cycle.
REQ-025 HOLD with accept=1 and start=1 (len>=1) SHALL enter FETCH directly (back-to-back), valid=0 next cycle.
REQ-026 Byte lanes at index >= len SHALL read as zero.
REQ-027 start SHALL be ignored in FETCH, and in HOLD without accept.
REQ-028 pc_load in any state SHALL set pc=pc_in next cycle and enter IDLE with valid=0; an in-progress fetch SHALL be aborted and its bytes discarded.
REQ-029 pc_load SHALL take priority over start, accept and bus_ready in the same cycle.
REQ-030 pc SHALL wrap from 2**ADDR_N-1 to 0 without error.

Reset
REQ-031 n_reset=0 at a rising edge SHALL set pc=RESET_PC, state=IDLE, valid=0, bus_oe=0, ins_bytes=0, count=0, with priority over all other inputs.
REQ-032 Reset asserted mid-FETCH SHALL abort the fetch; no byte captured that cycle.

Structure
REQ-033 The FSM state enum (fetch_state_t) SHALL reside in typepkg.
REQ-034 The program counter (load, increment, wrap) SHALL be a sub-module pc_counter parametrised by ADDR_N and RESET_PC.
REQ-035 Byte buffer SHALL be a MAX_BYTES-entry register array indexed by count.

Verification
REQ-036 Reset, then start len=3, memory 0x10/0x20/0x30 at 0..2, bus_ready=1 -> valid on cycle 4, ins_bytes=0x302010, pc=3.
REQ-037 start len=2, bus_ready low 2 cycles before each byte -> bus_addr held stable during waits, valid after 7 cycles, pc advanced by exactly 2.
REQ-038 pc_load pc_in=0xFFFF, start len=2 -> bytes read from 0xFFFF then 0x0000, pc=0x0001.
REQ-039 pc_load=1 during FETCH after 1 byte -> next cycle IDLE, valid=0, pc=pc_in, no further bus_oe.
REQ-040 HOLD with accept=1 and start=1 len=1 -> valid falls, new fetch issued next cycle, ins_bytes upper lanes zero; len=0 in IDLE -> no bus_oe.
REQ-041 n_reset=0 mid-FETCH -> next cycle pc=RESET_PC, bus_oe=0, valid=0, ins_bytes=0.
